// File: rtl/rx_ring_ctrl.sv
// Receive descriptor ring controller. Processes one descriptor at a time:
// fetches the head descriptor into a local slot over iDMA, hands the slot to
// rx_engine, waits for its status, writes the descriptor back, then advances
// RDH and raises a one-cycle receive-timer interrupt request.
module rx_ring_ctrl #(
  parameter int unsigned DESC_SLOTS = 4,
  parameter logic [15:0] LOCAL_BASE = 16'h0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        en,
  input  logic [63:0] RDBA,
  input  logic [19:0] RDLEN,
  input  logic [15:0] RDT,
  input  logic        rdh_set,
  input  logic [15:0] rdh_wdata,
  output logic [15:0] RDH,
  output logic        rxt0_req,
  output logic        busy,
  output logic [31:0] cmd_m_tdata,
  output logic        cmd_m_tvalid,
  output logic        cmd_m_tlast,
  input  logic        cmd_m_tready,
  input  logic [31:0] stat_s_tdata,
  input  logic        stat_s_tvalid,
  input  logic        stat_s_tlast,
  output logic        stat_s_tready,
  output logic [31:0] idma_m_tdata,
  output logic        idma_m_tvalid,
  output logic        idma_m_tlast,
  input  logic        idma_m_tready,
  input  logic [31:0] idma_s_tdata,
  input  logic        idma_s_tvalid,
  input  logic        idma_s_tlast,
  output logic        idma_s_tready
);

  localparam int unsigned SW = (DESC_SLOTS > 1) ? $clog2(DESC_SLOTS) : 1;
  localparam logic [11:0] DESC_BYTES = 12'd16;

  typedef enum logic [3:0] {
    S_IDLE, S_F_C1, S_F_C2, S_F_C3, S_F_ACK, S_CMD, S_STAT,
    S_W_C1, S_W_C2, S_W_C3, S_W_ACK, S_ADV
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] slot_q;
  logic [15:0]   rdh_q;
  logic [15:0]   local_q;
  logic [63:0]   host_q;

  logic [15:0]   ring_cnt;
  logic [15:0]   rdh_inc;
  logic [15:0]   rdh_next;
  logic [15:0]   slot_addr;
  logic [63:0]   host_addr;
  logic [15:0]   local_src;
  logic [63:0]   host_src;
  logic          start;
  logic          idma_m_fire, idma_s_fire, cmd_fire, stat_fire;

  logic [31:0]   idma_m_tdata_d, cmd_m_tdata_d;
  logic          idma_m_tvalid_d, idma_m_tlast_d, idma_s_tready_d;
  logic          cmd_m_tvalid_d, cmd_m_tlast_d, stat_s_tready_d;
  logic          rxt0_req_d, busy_d;

  // Status and response payloads are not interpreted: errors belong to the caller.
  logic unused_ok;
  assign unused_ok = ^{stat_s_tdata, stat_s_tlast, idma_s_tdata, idma_s_tlast, RDLEN[3:0]};

  // Ring arithmetic and handshake qualifiers.
  always_comb begin
    ring_cnt    = RDLEN[19:4];
    rdh_inc     = rdh_q + 16'd1;
    rdh_next    = (rdh_inc == ring_cnt) ? '0 : rdh_inc;
    slot_addr   = LOCAL_BASE + {{(12 - SW){1'b0}}, slot_q, 4'h0};
    host_addr   = RDBA + {44'd0, rdh_q, 4'h0};
    start       = (state_q == S_IDLE) && en && (rdh_q != RDT);
    // Leaving IDLE the latched addresses are not yet valid; use the live ones.
    local_src   = (state_q == S_IDLE) ? slot_addr : local_q;
    host_src    = (state_q == S_IDLE) ? host_addr : host_q;
    idma_m_fire = idma_m_tvalid && idma_m_tready;
    idma_s_fire = idma_s_tvalid && idma_s_tready;
    cmd_fire    = cmd_m_tvalid && cmd_m_tready;
    stat_fire   = stat_s_tvalid && stat_s_tready;
  end

  // Next-state sequencing of one descriptor.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)       state_d = S_F_C1;
      S_F_C1:  if (idma_m_fire) state_d = S_F_C2;
      S_F_C2:  if (idma_m_fire) state_d = S_F_C3;
      S_F_C3:  if (idma_m_fire) state_d = S_F_ACK;
      S_F_ACK: if (idma_s_fire) state_d = S_CMD;
      S_CMD:   if (cmd_fire)    state_d = S_STAT;
      S_STAT:  if (stat_fire)   state_d = S_W_C1;
      S_W_C1:  if (idma_m_fire) state_d = S_W_C2;
      S_W_C2:  if (idma_m_fire) state_d = S_W_C3;
      S_W_C3:  if (idma_m_fire) state_d = S_W_ACK;
      S_W_ACK: if (idma_s_fire) state_d = S_ADV;
      S_ADV:                    state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    idma_m_tvalid_d = 1'b0;
    idma_m_tlast_d  = 1'b0;
    idma_m_tdata_d  = '0;
    idma_s_tready_d = 1'b0;
    cmd_m_tvalid_d  = 1'b0;
    cmd_m_tlast_d   = 1'b0;
    cmd_m_tdata_d   = '0;
    stat_s_tready_d = 1'b0;
    rxt0_req_d      = 1'b0;
    busy_d          = (state_d != S_IDLE);
    unique case (state_d)
      S_F_C1: begin
        idma_m_tvalid_d = 1'b1;
        idma_m_tdata_d  = {1'b0, 3'b000, DESC_BYTES, local_src};
      end
      S_F_C2: begin
        idma_m_tvalid_d = 1'b1;
        idma_m_tdata_d  = host_src[31:0];
      end
      S_F_C3: begin
        idma_m_tvalid_d = 1'b1;
        idma_m_tlast_d  = 1'b1;
        idma_m_tdata_d  = host_src[63:32];
      end
      S_W_C1: begin
        idma_m_tvalid_d = 1'b1;
        idma_m_tdata_d  = {1'b1, 3'b000, DESC_BYTES, local_q};
      end
      S_W_C2: begin
        idma_m_tvalid_d = 1'b1;
        idma_m_tdata_d  = host_q[31:0];
      end
      S_W_C3: begin
        idma_m_tvalid_d = 1'b1;
        idma_m_tlast_d  = 1'b1;
        idma_m_tdata_d  = host_q[63:32];
      end
      S_F_ACK, S_W_ACK: idma_s_tready_d = 1'b1;
      S_CMD: begin
        cmd_m_tvalid_d = 1'b1;
        cmd_m_tlast_d  = 1'b1;
        cmd_m_tdata_d  = {16'h0000, local_q};
      end
      S_STAT: stat_s_tready_d = 1'b1;
      S_ADV:  rxt0_req_d      = 1'b1;
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      idma_m_tvalid <= 1'b0;
      idma_m_tlast  <= 1'b0;
      idma_m_tdata  <= '0;
      idma_s_tready <= 1'b0;
      cmd_m_tvalid  <= 1'b0;
      cmd_m_tlast   <= 1'b0;
      cmd_m_tdata   <= '0;
      stat_s_tready <= 1'b0;
      rxt0_req      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      idma_m_tvalid <= idma_m_tvalid_d;
      idma_m_tlast  <= idma_m_tlast_d;
      idma_m_tdata  <= idma_m_tdata_d;
      idma_s_tready <= idma_s_tready_d;
      cmd_m_tvalid  <= cmd_m_tvalid_d;
      cmd_m_tlast   <= cmd_m_tlast_d;
      cmd_m_tdata   <= cmd_m_tdata_d;
      stat_s_tready <= stat_s_tready_d;
      rxt0_req      <= rxt0_req_d;
      busy          <= busy_d;
    end
  end

  // Ring head, slot rotation and per-descriptor address latches.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdh_q   <= '0;
      slot_q  <= '0;
      local_q <= '0;
      host_q  <= '0;
    end else begin
      if (start) begin
        local_q <= slot_addr;
        host_q  <= host_addr;
      end
      if (state_q == S_ADV) begin
        rdh_q  <= rdh_next;
        slot_q <= slot_q + SW'(1);
      end else if ((state_q == S_IDLE) && !en && rdh_set) begin
        rdh_q <= rdh_wdata;
      end
    end
  end

  assign RDH = rdh_q;

endmodule

// File: tb/tb_rx_ring_ctrl.sv
// Scoreboarded bench for rx_ring_ctrl: a descriptor-level model predicts every
// iDMA/command beat and RDH value; responders emulate rx_engine and iDMA.
module tb_rx_ring_ctrl;

  localparam int unsigned SLOTS = 4;
  localparam logic [15:0] LBASE = 16'h0000;

  logic        aclk, aresetn, en, rdh_set;
  logic [63:0] RDBA;
  logic [19:0] RDLEN;
  logic [15:0] RDT, rdh_wdata, RDH;
  logic        rxt0_req, busy;
  logic [31:0] cmd_m_tdata, stat_s_tdata, idma_m_tdata, idma_s_tdata;
  logic        cmd_m_tvalid, cmd_m_tlast, cmd_m_tready;
  logic        stat_s_tvalid, stat_s_tlast, stat_s_tready;
  logic        idma_m_tvalid, idma_m_tlast, idma_m_tready;
  logic        idma_s_tvalid, idma_s_tlast, idma_s_tready;

  rx_ring_ctrl #(.DESC_SLOTS(SLOTS), .LOCAL_BASE(LBASE)) dut (
    .aclk(aclk), .aresetn(aresetn), .en(en), .RDBA(RDBA), .RDLEN(RDLEN), .RDT(RDT),
    .rdh_set(rdh_set), .rdh_wdata(rdh_wdata), .RDH(RDH), .rxt0_req(rxt0_req), .busy(busy),
    .cmd_m_tdata(cmd_m_tdata), .cmd_m_tvalid(cmd_m_tvalid), .cmd_m_tlast(cmd_m_tlast),
    .cmd_m_tready(cmd_m_tready),
    .stat_s_tdata(stat_s_tdata), .stat_s_tvalid(stat_s_tvalid), .stat_s_tlast(stat_s_tlast),
    .stat_s_tready(stat_s_tready),
    .idma_m_tdata(idma_m_tdata), .idma_m_tvalid(idma_m_tvalid), .idma_m_tlast(idma_m_tlast),
    .idma_m_tready(idma_m_tready),
    .idma_s_tdata(idma_s_tdata), .idma_s_tvalid(idma_s_tvalid), .idma_s_tlast(idma_s_tlast),
    .idma_s_tready(idma_s_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int unsigned n_checks = 0, n_pass = 0;
  bit          bp = 1'b0;
  int unsigned pulse_cnt = 0;

  logic [32:0] exp_idma[$];
  logic [31:0] exp_cmd[$];
  logic [15:0] exp_rdh[$];
  logic [15:0] stat_q[$];
  logic [15:0] resp_q[$];

  // Descriptor-level reference state
  logic [63:0] m_rdba;
  int unsigned m_rdh, m_slot, m_ring;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s timeout got=expired exp=handshake", name);
  endtask

  // Predict n descriptors from the ring rules: host slot = base + 16*head.
  task automatic predict(input int unsigned n);
    logic [63:0] h;
    logic [15:0] la;
    for (int unsigned i = 0; i < n; i++) begin
      h  = m_rdba + 64'(m_rdh) * 64'd16;
      la = LBASE + 16'(m_slot * 16);
      exp_idma.push_back({1'b0, 32'h0010_0000 | {16'h0, la}});
      exp_idma.push_back({1'b0, h[31:0]});
      exp_idma.push_back({1'b1, h[63:32]});
      exp_cmd.push_back({16'h0, la});
      exp_idma.push_back({1'b0, 32'h8010_0000 | {16'h0, la}});
      exp_idma.push_back({1'b0, h[31:0]});
      exp_idma.push_back({1'b1, h[63:32]});
      m_rdh  = (m_rdh + 1) % m_ring;
      m_slot = (m_slot + 1) % SLOTS;
      exp_rdh.push_back(16'(m_rdh));
    end
  endtask

  // Ready/backpressure driver for the DUT's master ports
  initial begin
    idma_m_tready = 1'b0;
    cmd_m_tready  = 1'b0;
    forever begin
      @(posedge aclk); #1;
      idma_m_tready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      cmd_m_tready  = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // rx_engine emulation: returns the slot address after a command
  initial begin
    logic [15:0] a;
    bit got;
    stat_s_tvalid = 1'b0; stat_s_tdata = '0; stat_s_tlast = 1'b0;
    forever begin
      @(posedge aclk); #1;
      if (stat_q.size() > 0) begin
        a = stat_q.pop_front();
        repeat (bp ? $urandom_range(0, 3) : 0) @(posedge aclk);
        #1;
        stat_s_tvalid = 1'b1; stat_s_tdata = {16'h0, a}; stat_s_tlast = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
          @(negedge aclk);
          if (stat_s_tready) begin got = 1'b1; break; end
        end
        if (!got) timeout("stat_accept");
        @(posedge aclk); #1;
        stat_s_tvalid = 1'b0; stat_s_tlast = 1'b0;
      end
    end
  end

  // iDMA emulation: one response per complete command, IDE randomly set
  initial begin
    logic [15:0] a;
    bit got;
    idma_s_tvalid = 1'b0; idma_s_tdata = '0; idma_s_tlast = 1'b0;
    forever begin
      @(posedge aclk); #1;
      if (resp_q.size() > 0) begin
        a = resp_q.pop_front();
        repeat (bp ? $urandom_range(0, 3) : 0) @(posedge aclk);
        #1;
        idma_s_tvalid = 1'b1; idma_s_tlast = 1'b1;
        idma_s_tdata = {14'h0, 1'($urandom_range(0, 1)), 1'b1, a};
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
          @(negedge aclk);
          if (idma_s_tready) begin got = 1'b1; break; end
        end
        if (!got) timeout("idma_resp_accept");
        @(posedge aclk); #1;
        idma_s_tvalid = 1'b0; idma_s_tlast = 1'b0;
      end
    end
  end

  // Monitor: compares accepted beats, hold stability and RDH after each pulse
  logic [32:0] e_idma;
  logic [31:0] e_cmd, pv_idma, pv_cmd;
  logic        pv_idma_last;
  bit          st_idma = 0, st_cmd = 0, rxt_prev = 0;
  int unsigned beat_n = 0;
  logic [15:0] c1_local;

  always @(negedge aclk) begin
    if (!aresetn) begin
      st_idma = 0; st_cmd = 0; rxt_prev = 0; beat_n = 0;
    end else begin
      if (st_idma)
        chk("idma_hold", {idma_m_tvalid, idma_m_tlast, idma_m_tdata}, {1'b1, pv_idma_last, pv_idma});
      if (st_cmd)
        chk("cmd_hold", {cmd_m_tvalid, cmd_m_tdata}, {1'b1, pv_cmd});
      st_idma = idma_m_tvalid && !idma_m_tready;
      st_cmd  = cmd_m_tvalid && !cmd_m_tready;
      pv_idma = idma_m_tdata; pv_idma_last = idma_m_tlast; pv_cmd = cmd_m_tdata;

      if (idma_m_tvalid && idma_m_tready) begin
        if (exp_idma.size() == 0) chk("idma_unexpected", {idma_m_tlast, idma_m_tdata}, 33'h0);
        else begin
          e_idma = exp_idma.pop_front();
          chk("idma_beat", {idma_m_tlast, idma_m_tdata}, e_idma);
        end
        if (beat_n == 0) c1_local = idma_m_tdata[15:0];
        if (idma_m_tlast) begin resp_q.push_back(c1_local); beat_n = 0; end
        else beat_n++;
      end

      if (cmd_m_tvalid && cmd_m_tready) begin
        if (exp_cmd.size() == 0) chk("cmd_unexpected", cmd_m_tdata, 32'h0);
        else begin
          e_cmd = exp_cmd.pop_front();
          chk("cmd_beat", {cmd_m_tlast, cmd_m_tdata}, {1'b1, e_cmd});
        end
        stat_q.push_back(cmd_m_tdata[15:0]);
      end

      if (rxt_prev) begin
        chk("rxt_width", rxt0_req, 1'b0);
        if (exp_rdh.size() == 0) chk("rxt_unexpected", RDH, 16'hFFFF);
        else chk("rdh_adv", RDH, exp_rdh.pop_front());
      end
      if (rxt0_req && !rxt_prev) pulse_cnt++;
      rxt_prev = rxt0_req;
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctl"}, {idma_m_tvalid, cmd_m_tvalid, idma_s_tready, stat_s_tready,
                        idma_m_tlast, cmd_m_tlast, rxt0_req, busy}, 8'h00);
    chk({tag, "_tdata"}, {idma_m_tdata, cmd_m_tdata}, 64'h0);
    chk({tag, "_rdh"}, RDH, 16'h0);
  endtask

  task automatic wait_done(input int unsigned budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int unsigned k = 0; k < budget; k++) begin
      @(negedge aclk);
      if (!busy && !rxt0_req && exp_idma.size() == 0 && exp_cmd.size() == 0 &&
          exp_rdh.size() == 0) begin
        ok = 1'b1; break;
      end
    end
    if (ok) begin n_checks++; n_pass++; end
    else timeout({tag, "_done"});
  endtask

  task automatic write_rdh(input logic [15:0] v);
    step(); rdh_set = 1'b1; rdh_wdata = v;
    step(); rdh_set = 1'b0;
    @(negedge aclk);
  endtask

  task automatic do_reset();
    step();
    aresetn = 1'b0; en = 1'b0; RDT = '0;
    exp_idma.delete(); exp_cmd.delete(); exp_rdh.delete();
    stat_q.delete(); resp_q.delete();
    repeat (2) step();
    aresetn = 1'b1;
    m_rdh = 0; m_slot = 0;
  endtask

  initial begin
    bit ok, any_busy;
    int unsigned rdt_i, n;

    aresetn = 1'b0; en = 1'b0; rdh_set = 1'b0; rdh_wdata = '0;
    RDBA = 64'h1_0000_1000; RDLEN = 20'd128; RDT = 16'd0;
    m_rdba = RDBA; m_ring = 8; m_rdh = 0; m_slot = 0;
    @(negedge aclk);
    check_reset("reset");
    repeat (2) step();
    aresetn = 1'b1;

    // Single descriptor from head 0
    step();
    RDT = 16'd1; en = 1'b1;
    predict(1);
    wait_done(200, "t1");
    chk("t1_rdh", RDH, 16'd1);
    chk("t1_pulses", pulse_cnt, 1);
    write_rdh(16'd5);
    chk("rdh_set_ignored_en", RDH, 16'd1);

    // Wrap from last ring entry back to 0
    step(); en = 1'b0;
    write_rdh(16'd7);
    chk("t2_rdh_set", RDH, 16'd7);
    m_rdh = 7;
    step(); RDT = 16'd0; en = 1'b1;
    predict(1);
    wait_done(200, "t2");
    chk("t2_wrap", RDH, 16'd0);

    // Five descriptors from a fresh reset: slot rotation wraps
    do_reset();
    pulse_cnt = 0;
    step(); RDT = 16'd5; en = 1'b1;
    predict(5);
    wait_done(600, "t3");
    chk("t3_pulses", pulse_cnt, 5);
    chk("t3_rdh", RDH, 16'd5);

    // Randomized ring geometry and backpressure
    bp = 1'b1;
    for (int r = 0; r < 6; r++) begin
      step();
      RDBA = {$urandom, $urandom} & ~64'hF;
      if (m_rdh < 8 && $urandom_range(0, 1) == 1) RDLEN = 20'd128;
      else RDLEN = 20'd256;
      m_rdba = RDBA; m_ring = 32'(RDLEN) / 16;
      rdt_i = $urandom_range(0, m_ring - 1);
      n = (rdt_i + m_ring - m_rdh) % m_ring;
      RDT = 16'(rdt_i);
      predict(n);
      wait_done(80 * n + 100, "rand");
      chk("rand_rdh", RDH, 16'(rdt_i));
    end

    // en dropped while waiting for status
    step();
    RDT = 16'((m_rdh + 3) % m_ring);
    predict(1);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge aclk);
      if (cmd_m_tvalid && cmd_m_tready) begin ok = 1'b1; break; end
    end
    chk("t5_cmd_seen", ok, 1'b1);
    step(); en = 1'b0;
    wait_done(300, "t5");
    any_busy = 1'b0;
    repeat (30) begin @(negedge aclk); any_busy |= busy; end
    chk("t5_no_fetch", any_busy, 1'b0);
    chk("t5_rdh", RDH, 16'(m_rdh));
    write_rdh(16'd3);
    chk("t5_rdh_set", RDH, 16'd3);
    m_rdh = 3;

    // Reset while the write-back command is half sent
    bp = 1'b0;
    step(); step();
    RDT = 16'd4; en = 1'b1;
    predict(1);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge aclk);
      if (idma_m_tvalid && idma_m_tready && idma_m_tdata[31]) begin ok = 1'b1; break; end
    end
    chk("t6_wb_seen", ok, 1'b1);
    @(posedge aclk); #1;
    aresetn = 1'b0; en = 1'b0; RDT = '0;
    @(negedge aclk);
    check_reset("t6_reset");
    exp_idma.delete(); exp_cmd.delete(); exp_rdh.delete();
    stat_q.delete(); resp_q.delete();
    m_rdh = 0; m_slot = 0;
    step(); aresetn = 1'b1;
    step(); en = 1'b1;
    any_busy = 1'b0;
    repeat (20) begin @(negedge aclk); any_busy |= busy | idma_m_tvalid; end
    chk("t6_idle_after", any_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_ring_ctrl.md
Name: rx_ring_ctrl

Overview:
Receive descriptor ring controller that sequences rx_engine one descriptor at a time.
- Fetches the descriptor at host ring head into a rotating local descriptor-RAM slot via iDMA.
- Commands rx_engine with the slot address and waits for its completion status.
- Writes the completed 16-byte descriptor back to host via iDMA, advances RDH, pulses the receive-timer interrupt request.

Parameters:
DESC_SLOTS, 4, number of 16-byte local descriptor slots (power of 2, 2..16)
LOCAL_BASE, 16'h0000, local byte address of slot 0 (16-byte aligned)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
en  in  1  RCTL.EN; ring processing enabled
RDBA  in  64  ring base host address (16-byte aligned)
RDLEN  in  20  ring length in bytes (multiple of 128, nonzero)
RDT  in  16  tail index (software-owned)
rdh_set  in  1  software write strobe for RDH
rdh_wdata  in  16  software RDH value
RDH  out  16  head index
rxt0_req  out  1  one-cycle interrupt request per written-back descriptor
busy  out  1  high whenever state != IDLE
cmd_m_tdata/tvalid/tlast/tready  out/out/out/in  32/1/1/1  to rx_engine: [15:0] slot address, [31:16]=0, single beat, tlast=1
stat_s_tdata/tvalid/tlast/tready  in/in/in/out  32/1/1/1  from rx_engine: [15:0] slot address
idma_m_tdata/tvalid/tlast/tready  out/out/out/in  32/1/1/1  iDMA command, 3 beats: C1 {dir,3'b0,bytes[11:0],local[15:0]}, C2 addr[31:0], C3 addr[63:32] with tlast
idma_s_tdata/tvalid/tlast/tready  in/in/in/out  32/1/1/1  iDMA response: [17]=IDE, [16]=RS, [15:0] local address

Behaviour:
- Reset: all tvalid=0, all tready=0, tlast=0, tdata=0, RDH=0, rxt0_req=0, busy=0, slot index=0, state=IDLE.
- Transfers occur only on tvalid&tready. Outputs are registered; tvalid/tdata hold until accepted.
- Derived values:
  - ring_cnt = RDLEN[19:4].
  - host_addr = RDBA + {RDH,4'h0}, 64-bit add.
  - slot_addr = LOCAL_BASE + {slot,4'h0}.
- States:
  - IDLE: if en && RDH!=RDT, latch slot_addr and host_addr -> F_C1; otherwise stay.
  - F_C1/F_C2/F_C3: send fetch command: dir=0 (IN), bytes=16, local=slot_addr. Advance on accept. Only F_C3 drives tlast=1. -> F_ACK.
  - F_ACK: idma_s_tready=1; on response -> CMD.
  - CMD: cmd_m_tvalid=1, tdata={16'b0,slot_addr}; on accept -> STAT.
  - STAT: stat_s_tready=1; on beat -> W_C1.
  - W_C1..W_C3: send write-back command, dir=1 (OUT), bytes=16, same local and host address. -> W_ACK.
  - W_ACK: on response -> ADV.
  - ADV (one cycle): RDH <= (RDH+1==ring_cnt) ? 0 : RDH+1; slot <= slot+1 mod DESC_SLOTS; rxt0_req=1 for this cycle only. -> IDLE.
- Response tready is asserted only in F_ACK/W_ACK; cmd/stat handshakes are not accepted in any other state.
- Response local-address mismatch or IDE=1: still proceed. IDE is not interpreted here; error policy belongs to the caller.
- en deasserted mid-operation: the in-flight descriptor completes through ADV, then the block stays in IDLE. A fetch never starts with en=0.
- rdh_set: honoured only in IDLE with en=0 (RDH<=rdh_wdata); ignored otherwise.
- RDT changes take effect at the next IDLE evaluation. RDT>=ring_cnt is software error: block runs until RDH==RDT never matches; no protection is required.
- Ring wrap: RDH=ring_cnt-1 advances to 0. Slot index wraps independently.
- Full throughput is not required; one descriptor is in flight at a time.
- Reset asserted mid-operation: immediate return to reset values; any half-sent iDMA command is abandoned.

Test Plan:
1. RDBA=0x1_0000_1000, RDLEN=128, RDT=1, en=1 -> fetch C1=0x0010_0000, C2=0x0000_1000, C3=0x0000_0001; cmd tdata=0x0000_0000; write-back C1=0x8010_0000; RDH=1; one rxt0_req pulse; back to IDLE.
2. RDH=7, RDT=0, RDLEN=128 -> one descriptor processed at host 0x...1070, RDH wraps to 0.
3. RDT=5 from RDH=0, DESC_SLOTS=4 -> slot addresses 0x00,0x10,0x20,0x30,0x00 in order; five rxt0_req pulses; RDH=5.
4. Random backpressure on idma_m_tready/cmd_m_tready -> tdata stable while tvalid high; beat order and content unchanged.
5. en dropped during STAT -> write-back and ADV still complete; no further fetch despite RDH!=RDT. With en=0, rdh_set with 3 -> RDH=3.
6. aresetn asserted during W_C2 -> all outputs at reset values next edge; RDH=0.
